// File: rtl/rr_mux_reg_pkg.sv
// ============================================================================
// Module : rr_mux_reg_pkg
// Brief  : Shared mode constants and channel-slicing helper for rr_mux_reg.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef RR_MUX_REG_PKG_SV
`define RR_MUX_REG_PKG_SV

// Extracts channel idx from a flattened bus of width-bit channels.
`define RR_CH_SLICE(vec, idx, width) vec[(idx)*(width) +: (width)]

package rr_mux_reg_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

`endif

`default_nettype wire

// File: rtl/rr_mux_reg_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; searches from ptr+1 modulo N.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import rr_mux_reg_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int SW = $clog2(N);

  // The last step (k = N) revisits ptr itself, so a lone requester always wins.
  always_comb begin
    int idx;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!gnt_any && req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = SW'(idx);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux_reg.sv
// ============================================================================
// Module : rr_mux_reg
// Brief  : N-channel registered mux, fixed-select or round-robin, valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_mux_reg
  import rr_mux_reg_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [$clog2(N)-1:0] sel,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr;
  logic [SW-1:0] arb_idx;
  logic          arb_any;
  logic          load_en;
  logic          fixed_valid;
  logic [SW-1:0] grant;
  logic          grant_valid;
  logic [W-1:0]  grant_data;

  rr_arbiter #(.N(N)) u_arbiter (
    .req     (in_valid),
    .ptr     (ptr),
    .en      (mode == MODE_RR),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign load_en = !out_valid || out_ready;

  // sel values without a matching channel (non-power-of-two N) yield no grant.
  always_comb begin
    fixed_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sel == SW'(i)) fixed_valid = in_valid[i];
    end
  end

  assign grant       = (mode == MODE_RR) ? arb_idx : sel;
  assign grant_valid = (mode == MODE_RR) ? arb_any : fixed_valid;

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        grant_data  = `RR_CH_SLICE(in_data, i, W);
        in_ready[i] = load_en && grant_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= SW'(N - 1);
    end else if (load_en) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= grant_data;
        out_chan <= grant;
        if (mode == MODE_RR) ptr <= grant;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_reg.sv
// ============================================================================
// Module : tb_rr_mux_reg
// Brief  : Scoreboard bench for rr_mux_reg with directed vectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_reg;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic          mode;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic          out_valid;
  logic          out_ready;

  int checks = 0;
  int fails  = 0;

  // Each entry is {chan, data} of one expected output transfer.
  logic [SW+W-1:0] exp_q[$];

  rr_mux_reg #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input int c, input int d);
    exp_q.push_back({SW'(c), W'(d)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  // Monitor: a transfer is a cycle where the DUT presents a word and it is accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_word: got chan %0d data %0d, queue empty", out_chan, out_data);
        end else begin
          logic [SW+W-1:0] e;
          e = exp_q.pop_front();
          check("out_chan", 32'(out_chan), 32'(e[SW+W-1:W]));
          check("out_data", 32'(out_data), 32'(e[W-1:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    in_data   = {2'd3, 2'd2, 2'd1, 2'd0};
    mode      = 1'b0;
    sel       = '0;
    in_valid  = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    // Reset held with every input valid.
    in_valid = '1;
    mode     = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_out_chan",  32'(out_chan),  0);
    in_valid = '0;
    rst_n    = 1'b1;

    // Asynchronous reset drops a stalled word without a clock edge.
    out_ready = 1'b0;
    in_valid  = '1;
    tick();
    check("stall_before_rst_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    do_reset();

    // Fixed select of channel 2.
    mode     = 1'b0;
    sel      = 2'd2;
    in_valid = '1;
    repeat (5) expect_word(2, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fixed_in_ready", 32'(in_ready), 32'h4);
    end
    drain();
    do_reset();

    // Round-robin over all channels.
    mode     = 1'b1;
    in_valid = '1;
    for (int i = 0; i < 6; i++) expect_word(i % 4, i % 4);
    repeat (6) tick();
    drain();
    do_reset();

    // Round-robin skipping idle channels, then a single requester.
    mode     = 1'b1;
    in_valid = 4'b1010;
    expect_word(1, 1); expect_word(3, 3); expect_word(1, 1); expect_word(3, 3);
    repeat (4) tick();
    in_valid = 4'b0010;
    repeat (3) expect_word(1, 1);
    repeat (3) tick();
    drain();
    do_reset();

    // Backpressure after the first capture, then release with no bubble.
    mode      = 1'b1;
    in_valid  = '1;
    out_ready = 1'b0;
    expect_word(0, 0);
    expect_word(1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", 32'(in_ready),  0);
      check("stall_chan",     32'(out_chan),  0);
      check("stall_data",     32'(out_data),  0);
      check("stall_valid",    32'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    check("release_valid", 32'(out_valid), 1);
    check("release_chan",  32'(out_chan),  1);
    drain();
    do_reset();

    // Fixed select of an idle channel.
    mode     = 1'b0;
    sel      = 2'd0;
    in_valid = 4'b1101;
    expect_word(0, 0);
    tick();
    sel = 2'd1;
    tick();
    check("idle_out_valid", 32'(out_valid), 0);
    check("idle_in_ready",  32'(in_ready),  0);
    in_valid = 4'b1111;
    expect_word(1, 1);
    tick();
    check("idle_raise_valid", 32'(out_valid), 1);
    check("idle_raise_data",  32'(out_data),  1);
    drain();

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
